// File: rtl/hw_cmd_responder.sv
// Hardware end of the software PIO command handshake: double-buffered object data with a frame-aligned commit.
// Optional watchdog on the wait states is enabled with `define HW_CMD_TIMEOUT_EN.
module hw_cmd_responder #(
    parameter int unsigned NUM_PORTS   = 10,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 50000000
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic [1:0]                  to_hw_sig_export,
    input  logic [NUM_PORTS*DATA_W-1:0] to_hw_port_flat,
    input  logic                        frame_tick,
    output logic [1:0]                  to_sw_sig_export,
    output logic [NUM_PORTS*DATA_W-1:0] active_data,
    output logic                        active_valid,
    output logic                        commit_pulse,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int unsigned BUS_W = NUM_PORTS * DATA_W;

    localparam logic [1:0] CMD_IDLE   = 2'b00;
    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_COMMIT = 2'b10;
    localparam logic [1:0] CMD_CLEAR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_WAIT_FRAME,
        S_CLEAR,
        S_WAIT_REL
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         sig_q;
    logic               armed;
    logic [1:0]         to_sw_nxt;
    logic [BUS_W-1:0]   shadow;
    logic               accept;
    logic               shadow_ld;
    logic               shadow_clr;
    logic               active_ld;
    logic               active_clr;
    logic               commit_nxt;

`ifdef HW_CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0]   wait_cnt;
    logic               in_wait;
    logic               timeout_hit;
    logic               timeout_q;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sig_q            <= CMD_IDLE;
            state            <= S_IDLE;
            armed            <= 1'b0;
            to_sw_sig_export <= CMD_IDLE;
            commit_pulse     <= 1'b0;
        end else begin
            sig_q            <= to_hw_sig_export;
            state            <= state_nxt;
            to_sw_sig_export <= to_sw_nxt;
            commit_pulse     <= commit_nxt;
            // A command must be preceded by IDLE on the bus before it can run again.
            if (sig_q == CMD_IDLE) begin
                armed <= 1'b1;
            end else if (accept) begin
                armed <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        to_sw_nxt  = to_sw_sig_export;
        accept     = 1'b0;
        shadow_ld  = 1'b0;
        shadow_clr = 1'b0;
        active_ld  = 1'b0;
        active_clr = 1'b0;
        commit_nxt = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (armed && (sig_q != CMD_IDLE)) begin
                    accept = 1'b1;
                    unique case (sig_q)
                        CMD_WRITE:  state_nxt = S_CAPTURE;
                        CMD_COMMIT: state_nxt = S_WAIT_FRAME;
                        default:    state_nxt = S_CLEAR;
                    endcase
                end
            end
            S_CAPTURE: begin
                shadow_ld = 1'b1;
                to_sw_nxt = CMD_WRITE;
                state_nxt = S_WAIT_REL;
            end
            S_WAIT_FRAME: begin
                // The frame boundary wins over a simultaneous software abort.
                if (frame_tick) begin
                    active_ld  = 1'b1;
                    commit_nxt = 1'b1;
                    to_sw_nxt  = CMD_COMMIT;
                    state_nxt  = S_WAIT_REL;
                end else if (sig_q == CMD_IDLE) begin
                    state_nxt = S_IDLE;
                end
            end
            S_CLEAR: begin
                shadow_clr = 1'b1;
                active_clr = 1'b1;
                to_sw_nxt  = CMD_CLEAR;
                state_nxt  = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (sig_q == CMD_IDLE) begin
                    to_sw_nxt = CMD_IDLE;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

`ifdef HW_CMD_TIMEOUT_EN
        in_wait     = (state == S_WAIT_FRAME) || (state == S_WAIT_REL);
        timeout_hit = in_wait && (state_nxt == state) &&
                      (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
        if (timeout_hit) begin
            state_nxt = S_IDLE;
            to_sw_nxt = CMD_IDLE;
        end
`endif
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            shadow       <= '0;
            active_data  <= '0;
            active_valid <= 1'b0;
        end else begin
            if (shadow_ld) begin
                shadow <= to_hw_port_flat;
            end else if (shadow_clr) begin
                shadow <= '0;
            end

            if (active_ld) begin
                active_data  <= shadow;
                active_valid <= 1'b1;
            end else if (active_clr) begin
                active_data  <= '0;
                active_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

`ifdef HW_CMD_TIMEOUT_EN
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            // Restart on every state change so each wait state gets its own budget.
            if ((state_nxt != state) || !in_wait) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (accept) begin
                timeout_q <= 1'b0;
            end else if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    // TIMEOUT_CYC has no effect without the watchdog; the flag is a constant 0.
    assign timeout_err = (TIMEOUT_CYC == 0) & 1'b0;
`endif

endmodule

// File: tb/tb_hw_cmd_responder.sv
// Directed bench for hw_cmd_responder: expectations track the handshake at transaction level.
`timescale 1ns/1ps
module tb_hw_cmd_responder;

    localparam int unsigned NP = 10;
    localparam int unsigned DW = 32;
`ifdef HW_CMD_TIMEOUT_EN
    localparam int unsigned TO_CYC    = 16;
    localparam int unsigned LONG_WAIT = 8;
    localparam int unsigned TICK_DLY  = 8;
`else
    localparam int unsigned TO_CYC    = 50000000;
    localparam int unsigned LONG_WAIT = 100;
    localparam int unsigned TICK_DLY  = 20;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [1:0]         sig = 2'b00;
    logic [NP*DW-1:0]   ports = '0;
    logic               frame_tick = 1'b0;
    logic [1:0]         to_sw;
    logic [NP*DW-1:0]   active_data;
    logic               active_valid;
    logic               commit_pulse;
    logic               busy;
    logic               timeout_err;

    hw_cmd_responder #(
        .NUM_PORTS  (NP),
        .DATA_W     (DW),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .to_hw_sig_export(sig),
        .to_hw_port_flat (ports),
        .frame_tick      (frame_tick),
        .to_sw_sig_export(to_sw),
        .active_data     (active_data),
        .active_valid    (active_valid),
        .commit_pulse    (commit_pulse),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    // Transaction-level expectations, updated by the stimulus just after the edge where they take effect.
    logic [1:0]       exp_sw = 2'b00;
    logic [NP*DW-1:0] exp_active = '0;
    logic [NP*DW-1:0] shadow_m = '0;
    logic             exp_valid = 1'b0;
    logic             exp_commit = 1'b0;
    logic             exp_busy = 1'b0;
    logic             exp_terr = 1'b0;

    task automatic chk(input string name, input logic [NP*DW-1:0] act, input logic [NP*DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("to_sw", {{(NP*DW-2){1'b0}}, to_sw}, {{(NP*DW-2){1'b0}}, exp_sw});
            chk("active_data", active_data, exp_active);
            chk("active_valid", {{(NP*DW-1){1'b0}}, active_valid}, {{(NP*DW-1){1'b0}}, exp_valid});
            chk("commit_pulse", {{(NP*DW-1){1'b0}}, commit_pulse}, {{(NP*DW-1){1'b0}}, exp_commit});
            chk("busy", {{(NP*DW-1){1'b0}}, busy}, {{(NP*DW-1){1'b0}}, exp_busy});
            chk("timeout_err", {{(NP*DW-1){1'b0}}, timeout_err}, {{(NP*DW-1){1'b0}}, exp_terr});
        end
    end

    function automatic logic [NP*DW-1:0] pack_seq(input logic [31:0] base, input logic [31:0] stride);
        logic [NP*DW-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            v[i*DW +: DW] = base + i * stride;
        end
        return v;
    endfunction

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // WRITE: registered command, accept, capture -> ack on the third edge.
    task automatic do_write(input logic [NP*DW-1:0] vals);
        ports = vals;
        sig = 2'b01;
        step(2);
        exp_busy = 1'b1;
        exp_terr = 1'b0;
        step(1);
        exp_sw = 2'b01;
        shadow_m = vals;
    endtask

    task automatic release_cmd();
        sig = 2'b00;
        step(2);
        exp_sw = 2'b00;
        exp_busy = 1'b0;
    endtask

    task automatic do_commit(input int unsigned dly);
        sig = 2'b10;
        step(2);
        exp_busy = 1'b1;
        step(dly);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        exp_active = shadow_m;
        exp_valid = 1'b1;
        exp_commit = 1'b1;
        exp_sw = 2'b10;
        step(1);
        exp_commit = 1'b0;
    endtask

    logic [NP*DW-1:0] vals1, vals4, vals5, vals6;

    initial begin
        vals1 = pack_seq(32'h1000_0000, 32'h1);
        vals4 = pack_seq(32'hA5A5_0100, 32'h0000_1111);
        vals5 = pack_seq(32'h0BAD_F00D, 32'h0101_0101);
        vals6 = pack_seq(32'h7777_0000, 32'h0000_0003);

        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        step(3);
        chk("reset_to_sw", {{(NP*DW-2){1'b0}}, to_sw}, '0);
        chk("reset_active", active_data, '0);
        rst_n = 1'b1;
        step(2);

        // 1: WRITE ack latency and release latency; active bank untouched.
        do_write(vals1);
        chk("t1_ack", {{(NP*DW-2){1'b0}}, to_sw}, {{(NP*DW-2){1'b0}}, 2'b01});
        chk("t1_active_unchanged", active_data, '0);
        release_cmd();
        chk("t1_busy_after_release", {{(NP*DW-1){1'b0}}, busy}, '0);

        // 2: tick in the cycle sig_q first shows COMMIT is ignored; a later tick commits.
        sig = 2'b10;
        step(1);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        exp_busy = 1'b1;
        step(TICK_DLY);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        exp_active = shadow_m;
        exp_valid = 1'b1;
        exp_commit = 1'b1;
        exp_sw = 2'b10;
        chk("t2_port3", {{(NP*DW-DW){1'b0}}, active_data[3*DW +: DW]}, {{(NP*DW-DW){1'b0}}, 32'h1000_0003});
        chk("t2_commit_pulse", {{(NP*DW-1){1'b0}}, commit_pulse}, {{(NP*DW-1){1'b0}}, 1'b1});
        chk("t2_ack", {{(NP*DW-2){1'b0}}, to_sw}, {{(NP*DW-2){1'b0}}, 2'b10});
        step(1);
        exp_commit = 1'b0;
        release_cmd();

        // 3: COMMIT aborted before any tick, then a stray tick while idle.
        sig = 2'b10;
        step(2);
        exp_busy = 1'b1;
        step(5);
        sig = 2'b00;
        step(2);
        exp_busy = 1'b0;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(2);
        chk("t3_active_kept", active_data, vals1);

        // 4: held WRITE with changing ports captures once; a switch to CLEAR without IDLE is ignored.
        do_write(vals4);
        for (int k = 0; k < int'(LONG_WAIT); k++) begin
            for (int unsigned i = 0; i < NP; i++) ports[i*DW +: DW] = $urandom;
            step(1);
        end
        sig = 2'b11;
        step(4);
        chk("t4_ack_held", {{(NP*DW-2){1'b0}}, to_sw}, {{(NP*DW-2){1'b0}}, 2'b01});
        release_cmd();
        do_commit(3);
        chk("t4_single_capture", active_data, vals4);
        release_cmd();

        // 5a: CLEAR wipes both banks.
        sig = 2'b11;
        step(2);
        exp_busy = 1'b1;
        step(1);
        exp_sw = 2'b11;
        exp_active = '0;
        exp_valid = 1'b0;
        shadow_m = '0;
        chk("t5_clear_valid", {{(NP*DW-1){1'b0}}, active_valid}, '0);
        release_cmd();

        // 5b: commit fresh data, then back-to-back release/COMMIT and reset while waiting for a frame.
        do_write(vals5);
        release_cmd();
        do_commit(2);
        chk("t5_committed", active_data, vals5);
        release_cmd();
        do_write(vals6);
        sig = 2'b00;
        step(1);
        sig = 2'b10;
        step(1);
        exp_sw = 2'b00;
        exp_busy = 1'b0;
        step(1);
        exp_busy = 1'b1;
        step(3);
        rst_n = 1'b0;
        sig = 2'b00;
        exp_sw = 2'b00;
        exp_active = '0;
        exp_valid = 1'b0;
        exp_commit = 1'b0;
        exp_busy = 1'b0;
        exp_terr = 1'b0;
        shadow_m = '0;
        #1;
        chk("t5_async_active", active_data, '0);
        chk("t5_async_busy", {{(NP*DW-1){1'b0}}, busy}, '0);
        chk("t5_async_valid", {{(NP*DW-1){1'b0}}, active_valid}, '0);
        step(2);
        rst_n = 1'b1;
        step(2);
        do_commit(3);
        chk("t5_shadow_was_reset", active_data, '0);
        chk("t5_valid_after_commit", {{(NP*DW-1){1'b0}}, active_valid}, {{(NP*DW-1){1'b0}}, 1'b1});
        release_cmd();

`ifdef HW_CMD_TIMEOUT_EN
        // 6: COMMIT with no tick times out and is not re-run while held; the next WRITE clears the flag.
        sig = 2'b10;
        step(2);
        exp_busy = 1'b1;
        step(TO_CYC);
        exp_busy = 1'b0;
        exp_terr = 1'b1;
        chk("t6_timeout_err", {{(NP*DW-1){1'b0}}, timeout_err}, {{(NP*DW-1){1'b0}}, 1'b1});
        step(20);
        sig = 2'b00;
        step(2);
        do_write(vals1);
        chk("t6_err_cleared", {{(NP*DW-1){1'b0}}, timeout_err}, '0);
        release_cmd();
`endif

        step(2);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
